// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-stage field
// widths, MEM/WB field offsets and the occupancy encoding.
package pipe_pkg;

    // Per-stage control / data widths
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 32;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 70;
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 67;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 67;

    // MEM/WB data field layout (LSB offsets)
    localparam int MEMWB_PCP2_LSB  = 0;
    localparam int MEMWB_ALU_LSB   = 16;
    localparam int MEMWB_STORE_LSB = 32;
    localparam int MEMWB_RD_LSB    = 48;
    localparam int MEMWB_SPARE_LSB = 51;

    // MEM/WB control bit positions
    localparam int MEMWB_REGWRITE_BIT = 0;
    localparam int MEMWB_REGSTORE_BIT = 1;

    // Number of entries held by a stage register
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Map the two slot valid bits onto an occupancy code; (0,1) cannot occur.
    function automatic occ_e occ_of(input logic main_v, input logic skid_v);
        occ_e occ;
        if (main_v && skid_v)
            occ = OCC_FULL;
        else if (main_v || skid_v)
            occ = OCC_ONE;
        else
            occ = OCC_EMPTY;
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a stage register: valid flag, control field and data
// field. Clearing a slot always zeroes control so a bubble never carries a
// live RegWrite; data is zeroed only when ZERO_DATA_ON_BUBBLE is set.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W              = 2,
    parameter int DATA_W              = 67,
    parameter bit ZERO_DATA_ON_BUBBLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Valid and control: clear wins over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
        end
    end

    // Data: optionally zeroed on a bubble, otherwise holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clear) begin
            if (ZERO_DATA_ON_BUBBLE)
                data <= '0;
        end else if (load) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with a 2-entry skid buffer.
// in_ready depends only on the skid valid flop, so no combinational path runs
// from out_ready to in_ready. flush turns both slots into bubbles. stall_cnt
// counts cycles where a valid entry is held back by downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W              = 2,
    parameter int DATA_W              = 67,
    parameter bit ZERO_DATA_ON_BUBBLE = 1'b0,
    parameter int CNT_W               = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    // Saturating increment: sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v)
            r = v;
        else
            r = v + 1'b1;
        return r;
    endfunction

    logic              main_v;
    logic              skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] main_src_ctrl;
    logic [DATA_W-1:0] main_src_data;

    assign accept = in_valid & in_ready;
    assign drain  = main_v & out_ready;

    // Main slot is refilled when it is empty or draining; the skid entry is
    // older than anything upstream, so it takes precedence as the source.
    assign main_load     = (accept & (~main_v | drain)) | (drain & skid_v);
    assign main_clear    = flush | (drain & ~skid_v & ~accept);
    assign main_src_ctrl = skid_v ? skid_ctrl : in_ctrl;
    assign main_src_data = skid_v ? skid_data : in_data;

    // Skid captures an accepted entry only when main is occupied and stalled
    assign skid_load  = accept & main_v & ~drain;
    assign skid_clear = flush | (skid_v & drain);

    pipe_slot #(
        .CTRL_W              (CTRL_W),
        .DATA_W              (DATA_W),
        .ZERO_DATA_ON_BUBBLE (ZERO_DATA_ON_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_src_ctrl),
        .in_data (main_src_data),
        .valid   (main_v),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_slot #(
        .CTRL_W              (CTRL_W),
        .DATA_W              (DATA_W),
        .ZERO_DATA_ON_BUBBLE (ZERO_DATA_ON_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (skid_v),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    assign out_valid = main_v;
    assign in_ready  = ~skid_v;
    assign occupancy = occ_of(main_v, skid_v);

    // Back-pressure counter: clear has priority; flush leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (main_v && !out_ready)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that generalises the fixed-field inter-stage latches (e.g. MEM/WB) into one reusable block.
- Carries a control field and a data field between stages under a valid/ready handshake.
- Provides a 2-entry skid buffer so `in_ready` is registered, plus synchronous flush that inserts a bubble and a saturating back-pressure counter.
- Instantiated between every pair of pipeline stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- CTRL_W, 2, width of control field (e.g. RegWrite, RegStore); forced to zero on every bubble.
- DATA_W, 67, width of data payload (e.g. PCP2 16 + ALUResult 16 + StoreMem 16 + Rd 3 + spare 16).
- ZERO_DATA_ON_BUBBLE, 0, 1 = `out_data` also cleared when the slot is invalid; 0 = data holds its last value.
- CNT_W, 8, width of stall counter.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry; registered.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  main slot holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control of main slot; zero when `out_valid`=0.
- out_data  out  DATA_W  data of main slot.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.
- stall_cnt_clr  in  1  synchronous clear of `stall_cnt`.

Behaviour:
- Reset (async, Reset=0): both slots invalid; `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid contents=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0. Outputs take these values immediately, without waiting for a clock edge.
- State (from main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1). State (0,1) is illegal and never reachable.
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- `in_ready` = ~skid_v, registered.
- EMPTY: Accept -> input loads main -> ONE.
- ONE:
  - Drain & Accept -> input loads main; stays ONE.
  - Drain only -> EMPTY.
  - Accept only -> input loads skid -> FULL.
  - Neither -> hold.
- FULL: Drain -> skid moves to main, skid cleared -> ONE. No accept is possible because `in_ready`=0.
- Latency: 1 cycle from Accept to `out_valid` when EMPTY, or when ONE with Drain. Throughput is 1 entry/cycle with `out_ready` held high.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- flush=1 at a clock edge:
  - both slots invalid; `out_ctrl`=0; skid ctrl=0.
  - data fields cleared if ZERO_DATA_ON_BUBBLE, else held.
  - any same-cycle Accept is discarded (flush wins).
  - a same-cycle Drain still counts as completed downstream.
  - `in_ready`=1 the next cycle.
- `out_ctrl` is zero whenever `out_valid`=0, so a bubble never asserts RegWrite.
- `occupancy` = main_v + skid_v, registered.
- `stall_cnt`:
  - +1 each cycle `out_valid` & ~`out_ready`; saturates at 2^CNT_W−1 (no wrap).
  - `stall_cnt_clr` has priority over increment.
  - flush does not clear the counter.
- All outputs are registered; there is no combinational path from in_* to out_* or from `out_ready` to `in_ready`.

Decomposition:
- Shared package `pipe_pkg`:
  - per-stage CTRL_W/DATA_W localparams (IFID, IDEX, EXMEM, MEMWB).
  - field offset constants, e.g. MEMWB_ALU_LSB, MEMWB_RD_LSB.
  - occupancy encodings EMPTY=0, ONE=1, FULL=2.
- One sub-module `pipe_slot`: a valid+ctrl+data register with load, clear, ZERO_DATA_ON_BUBBLE; instantiated twice (main, skid).

Test Plan:
- Reset mid-FULL: fill both slots, drop Reset for 3 ns between edges -> `out_valid`=0, `occupancy`=0, `in_ready`=1 immediately; `stall_cnt`=0.
- Streaming: `out_ready`=1, send data 0x0001..0x0010 back-to-back -> each appears 1 cycle later in order; `occupancy` never exceeds 1; `stall_cnt`=0.
- Back-pressure: `out_ready`=0, send 0xA, 0xB, 0xC -> A in main, B in skid, `in_ready`=0 from cycle 3, C held upstream. Raise `out_ready` -> outputs A, B, C in order; `stall_cnt` counts stalled cycles exactly.
- Flush with simultaneous accept: state ONE (ctrl=2'b11), flush=1 with `in_valid`=1 data 0x55 -> next cycle `out_valid`=0, `out_ctrl`=0, 0x55 never emitted.
- Bubble gating: ZERO_DATA_ON_BUBBLE=1, drain last entry -> `out_ctrl`=0, `out_data`=0. With ZERO_DATA_ON_BUBBLE=0 -> `out_data` holds last value, `out_ctrl`=0.
- Counter saturation: CNT_W=4, hold stall for 20 cycles -> `stall_cnt`=15. Assert `stall_cnt_clr` while the stall persists -> 0, then resumes counting at 1.
